// File: rtl/systolic_skew_feeder.sv
// Buffers whole activation vectors in a small FIFO and re-emits them diagonally skewed
// (lane i delayed i cycles) so wavefronts enter the systolic MAC array aligned.
module systolic_skew_feeder #(
    parameter int DATA_SIZE  = 8,
    parameter int MAC_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MAC_WIDTH*DATA_SIZE-1:0] in_data,
    input  logic                           in_last,
    output logic [MAC_WIDTH*DATA_SIZE-1:0] values_out,
    output logic [MAC_WIDTH-1:0]           lane_valid,
    output logic                           busy
);

    localparam int VecW   = MAC_WIDTH * DATA_SIZE;
    localparam int PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CntW   = $clog2(FIFO_DEPTH + 1);
    localparam int DrainW = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1;

    localparam logic [CntW-1:0]   FullCount = CntW'(FIFO_DEPTH);
    localparam logic [DrainW-1:0] DrainInit = DrainW'(MAC_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [DrainW-1:0] drainCnt_q, drainCnt_d;
    logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
    logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [VecW:0]     fifoMem_q [FIFO_DEPTH];

    logic          push;
    logic          pop;
    logic [VecW:0] headEntry;
    logic          popLast;

    // No full-bypass: a pop on the same edge does not open the door for a push.
    assign in_ready  = (count_q != FullCount);
    assign push      = in_valid && in_ready;
    assign pop       = (state_q == STREAM) && (count_q != '0);
    assign headEntry = fifoMem_q[rdPtr_q];
    assign popLast   = headEntry[VecW];

    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {in_last, in_data};
        end
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (pop && popLast) begin
                    if (MAC_WIDTH == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DRAIN;
                        drainCnt_d = DrainInit;
                    end
                end
            end
            DRAIN: begin
                drainCnt_d = drainCnt_q - 1'b1;
                if (drainCnt_q == DrainW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                drainCnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            drainCnt_q <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            drainCnt_q <= drainCnt_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
        end
    end

    // Lane i owns a private chain of i+1 stages; stage 0 takes a bubble whenever no pop happens.
    for (genvar lane = 0; lane < MAC_WIDTH; lane++) begin : g_lane
        logic [DATA_SIZE-1:0] data_q [lane+1];
        logic [lane:0]        valid_q;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s <= lane; s++) begin
                    data_q[s] <= '0;
                end
                valid_q <= '0;
            end else begin
                data_q[0]  <= pop ? headEntry[lane*DATA_SIZE +: DATA_SIZE] : '0;
                valid_q[0] <= pop;
                for (int s = 1; s <= lane; s++) begin
                    data_q[s]  <= data_q[s-1];
                    valid_q[s] <= valid_q[s-1];
                end
            end
        end

        assign values_out[lane*DATA_SIZE +: DATA_SIZE] = data_q[lane];
        assign lane_valid[lane]                        = valid_q[lane];
    end

    assign busy = (state_q != IDLE) || (count_q != '0) || (|lane_valid);

endmodule
